chi_aiu_ott_alloc_ctrl: RTL and testbench
=========================================

CHI_AIU_OTT_ALLOC_CTRL -- requirements
Module: chi_aiu_ott_alloc_ctrl

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 32, number of OTT entries (2..128).
REQ-002 SHALL have parameter N_RSV, default 4, entries reserved for high-QoS requests (< N_ENTRIES).
REQ-003 SHALL have parameter HI_QOS, default 12, minimum QoS value classed high.
REQ-004 SHALL have parameter STARV_THRESH, default 16, blocked-cycle count that enters starvation mode.
REQ-005 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-006 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-007 SHALL have port alloc_vld  input  1  allocation request valid.
REQ-008 SHALL have port alloc_qos  input  4  QoS of the request.
REQ-009 SHALL have port alloc_rdy  output  1  allocation accepted this cycle when high with alloc_vld.
REQ-010 SHALL have port alloc_id  output  clog2(N_ENTRIES)  granted entry index, valid when alloc_vld&&alloc_rdy.
REQ-011 SHALL have port dealloc_vld  input  1  entry retire pulse.
REQ-012 SHALL have port dealloc_id  input  clog2(N_ENTRIES)  entry to retire.
REQ-013 SHALL have port entry_validvec  output  N_ENTRIES  registered occupancy vector.
REQ-014 SHALL have port free_cnt  output  clog2(N_ENTRIES+1)  registered free-entry count.
REQ-015 SHALL have port starv_mode  output  1  registered starvation-mode flag.
REQ-016 SHALL have port dealloc_err  output  1  registered one-cycle pulse: dealloc of non-valid entry.

Function
REQ-017 SHALL classify request high when alloc_qos >= HI_QOS, else normal.
REQ-018 SHALL drive alloc_rdy combinationally: high request -> free_cnt>0; normal request -> free_cnt>N_RSV, or free_cnt>0 when starv_mode=1.
REQ-019 SHALL drive alloc_id combinationally as lowest index with entry_validvec bit 0; alloc_rdy SHALL be 0 when free_cnt=0 (full).
REQ-020 SHALL set entry_validvec[alloc_id] on the cycle after handshake; zero-cycle bubble, back-to-back grants every cycle permitted.
REQ-021 SHALL clear entry_validvec[dealloc_id] on the cycle after dealloc_vld when that bit is 1.
REQ-022 SHALL ignore dealloc of a bit already 0 and pulse dealloc_err next cycle; free_cnt unchanged.
REQ-023 SHALL compute alloc_id/alloc_rdy from pre-update state: an entry freed in cycle T is grantable no earlier than T+1.
REQ-024 SHALL update free_cnt by -1 on grant, +1 on valid dealloc, net 0 when both in same cycle; free_cnt always equals count of zero bits in entry_validvec.
REQ-025 SHALL keep a blocked counter, width clog2(STARV_THRESH+1), saturating at STARV_THRESH.
REQ-026 SHALL increment blocked counter each cycle a normal request has alloc_vld=1, alloc_rdy=0 and free_cnt>0; SHALL clear it on any normal grant or any cycle with alloc_vld=0.
REQ-027 SHALL hold blocked counter unchanged when free_cnt=0 (full stall is not starvation).
REQ-028 SHALL implement FSM NORMAL/STARV; NORMAL->STARV when blocked counter reaches STARV_THRESH-1 and increments (starv_mode high next cycle).
REQ-029 SHALL transition STARV->NORMAL the cycle after a normal grant, or the cycle after free_cnt > N_RSV is observed; blocked counter cleared on exit.
REQ-030 SHALL keep high-request eligibility unaffected by FSM state.

Reset
REQ-031 SHALL, on resetn low, asynchronously clear entry_validvec, starv_mode, dealloc_err, blocked counter; set free_cnt=N_ENTRIES; FSM=NORMAL.
REQ-032 SHALL discard in-flight grants/deallocs on reset mid-operation; first grant after deassert returns alloc_id=0.
REQ-033 SHALL produce alloc_rdy=0 while resetn low.

Verification
REQ-034 SHALL cover: 32 back-to-back high requests after reset -> alloc_id 0..31, free_cnt 0, 33rd alloc_rdy=0.
REQ-035 SHALL cover: free_cnt=4, normal request qos=3 -> alloc_rdy=0; high qos=12 same state -> alloc_rdy=1, alloc_id = lowest free.
REQ-036 SHALL cover: free_cnt=4, normal request held 16 cycles -> starv_mode=1 at cycle 17, grant following cycle, starv_mode=0 next cycle.
REQ-037 SHALL cover: full, dealloc_id=5 and alloc_vld same cycle -> alloc_rdy=0 that cycle, alloc_id=5 granted next cycle, free_cnt stays 0 after.
REQ-038 SHALL cover: dealloc_id=7 on free entry -> dealloc_err one-cycle pulse, free_cnt unchanged.
REQ-039 SHALL cover: resetn low while 10 entries valid and starv_mode=1 -> validvec 0, free_cnt 32, starv_mode 0 immediately.

Source files
------------

// File: rtl/chi_aiu_ott_alloc_ctrl.sv
// OTT entry allocator: lowest-free-index grant with a QoS reserve pool and
// starvation escalation for normal-QoS requests blocked behind that reserve.
module chi_aiu_ott_alloc_ctrl #(
  parameter int N_ENTRIES    = 32,
  parameter int N_RSV        = 4,
  parameter int HI_QOS       = 12,
  parameter int STARV_THRESH = 16
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           alloc_vld,
  input  logic [3:0]                     alloc_qos,
  output logic                           alloc_rdy,
  output logic [$clog2(N_ENTRIES)-1:0]   alloc_id,
  input  logic                           dealloc_vld,
  input  logic [$clog2(N_ENTRIES)-1:0]   dealloc_id,
  output logic [N_ENTRIES-1:0]           entry_validvec,
  output logic [$clog2(N_ENTRIES+1)-1:0] free_cnt,
  output logic                           starv_mode,
  output logic                           dealloc_err
);

  localparam int IDW = $clog2(N_ENTRIES);
  localparam int CW  = $clog2(N_ENTRIES + 1);
  localparam int BW  = $clog2(STARV_THRESH + 1);

  localparam logic [CW-1:0] RSV_C        = CW'(N_RSV);
  localparam logic [CW-1:0] FULL_C       = CW'(N_ENTRIES);
  localparam logic [3:0]    HI_C         = 4'(HI_QOS);
  localparam logic [BW-1:0] THRESH_C     = BW'(STARV_THRESH);
  localparam logic [BW-1:0] THRESH_M1_C  = BW'(STARV_THRESH - 1);

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_STARV  = 1'b1
  } state_t;

  state_t               state_reg, state_next;
  logic [BW-1:0]        blk_reg, blk_next;
  logic [N_ENTRIES-1:0] set_vec, clr_vec;
  logic [IDW-1:0]       free_id;
  logic                 is_high, any_free, grant, normal_grant, blocked;
  logic                 dealloc_ok;

  assign is_high      = (alloc_qos >= HI_C);
  assign any_free     = (free_cnt != '0);
  assign alloc_rdy    = resetn && any_free && (is_high || (free_cnt > RSV_C) || starv_mode);
  assign alloc_id     = free_id;
  assign grant        = alloc_vld && alloc_rdy;
  assign normal_grant = grant && !is_high;
  // A full table is a capacity stall, not starvation, so it never counts.
  assign blocked      = alloc_vld && !is_high && !alloc_rdy && any_free;
  assign starv_mode   = (state_reg == ST_STARV);

  always_comb begin
    free_id = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (!entry_validvec[i]) free_id = IDW'(i);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_ENTRIES; gi++) begin : g_entry
      assign set_vec[gi] = grant && (free_id == IDW'(gi));
      assign clr_vec[gi] = dealloc_vld && (dealloc_id == IDW'(gi)) && entry_validvec[gi];
    end
  endgenerate

  assign dealloc_ok = |clr_vec;

  always_comb begin
    state_next = state_reg;
    blk_next   = blk_reg;
    if (!alloc_vld || normal_grant) begin
      blk_next = '0;
    end else if (blocked && (blk_reg != THRESH_C)) begin
      blk_next = blk_reg + 1'b1;
    end
    case (state_reg)
      ST_NORMAL: begin
        if (blocked && (blk_reg == THRESH_M1_C)) state_next = ST_STARV;
      end
      ST_STARV: begin
        if (normal_grant || (free_cnt > RSV_C)) begin
          state_next = ST_NORMAL;
          blk_next   = '0;
        end
      end
      default: state_next = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= ST_NORMAL;
      blk_reg        <= '0;
      entry_validvec <= '0;
      free_cnt       <= FULL_C;
      dealloc_err    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      blk_reg        <= blk_next;
      entry_validvec <= (entry_validvec | set_vec) & ~clr_vec;
      dealloc_err    <= dealloc_vld && !dealloc_ok;
      case ({grant, dealloc_ok})
        2'b10:   free_cnt <= free_cnt - 1'b1;
        2'b01:   free_cnt <= free_cnt + 1'b1;
        default: free_cnt <= free_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_chi_aiu_ott_alloc_ctrl.sv
// Randomised and directed bench for the OTT allocator against a per-entry
// occupancy model that applies the allocation/starvation rules directly.
module tb_chi_aiu_ott_alloc_ctrl;

  localparam int N      = 32;
  localparam int RSV    = 4;
  localparam int HI     = 12;
  localparam int THRESH = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        alloc_vld = 1'b0;
  logic [3:0]  alloc_qos = '0;
  logic        alloc_rdy;
  logic [4:0]  alloc_id;
  logic        dealloc_vld = 1'b0;
  logic [4:0]  dealloc_id = '0;
  logic [31:0] entry_validvec;
  logic [5:0]  free_cnt;
  logic        starv_mode;
  logic        dealloc_err;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit occ[N];
  int blk;
  bit starv;
  bit err_exp;

  chi_aiu_ott_alloc_ctrl #(
    .N_ENTRIES(N), .N_RSV(RSV), .HI_QOS(HI), .STARV_THRESH(THRESH)
  ) dut (
    .clk(clk), .resetn(resetn),
    .alloc_vld(alloc_vld), .alloc_qos(alloc_qos),
    .alloc_rdy(alloc_rdy), .alloc_id(alloc_id),
    .dealloc_vld(dealloc_vld), .dealloc_id(dealloc_id),
    .entry_validvec(entry_validvec), .free_cnt(free_cnt),
    .starv_mode(starv_mode), .dealloc_err(dealloc_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) occ[i] = 1'b0;
    blk     = 0;
    starv   = 1'b0;
    err_exp = 1'b0;
  endtask

  task automatic check_regs();
    logic [31:0] vec;
    int fc;
    fc = 0;
    for (int i = 0; i < N; i++) begin
      vec[i] = occ[i];
      if (!occ[i]) fc++;
    end
    chk("entry_validvec", entry_validvec, vec);
    chk("free_cnt", free_cnt, fc);
    chk("starv_mode", starv_mode, starv);
    chk("dealloc_err", dealloc_err, err_exp);
  endtask

  // One clock of stimulus: check combinational grant, clock, then registered state.
  task automatic cycle(input bit v, input int q, input bit dv, input int did);
    int fc, lid;
    bit hi, erdy, grant, nblk, dok, derr, nstarv;
    alloc_vld   = v;
    alloc_qos   = 4'(q);
    dealloc_vld = dv;
    dealloc_id  = 5'(did);
    fc  = 0;
    lid = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!occ[i]) begin
        fc++;
        lid = i;
      end
    end
    hi   = (q >= HI);
    erdy = hi ? (fc > 0) : ((fc > RSV) || (starv && fc > 0));
    #1;
    chk("alloc_rdy", alloc_rdy, erdy);
    if (v && erdy) chk("alloc_id", alloc_id, lid);
    grant = v && erdy;
    nblk  = v && !hi && !erdy && (fc > 0);
    dok   = dv && occ[did];
    derr  = dv && !occ[did];
    @(posedge clk);
    nstarv = starv;
    if (!starv && nblk && blk == THRESH - 1) nstarv = 1'b1;
    if (starv && ((grant && !hi) || fc > RSV)) begin
      nstarv = 1'b0;
      blk    = 0;
    end else if (!v || (grant && !hi)) begin
      blk = 0;
    end else if (nblk && blk < THRESH) begin
      blk++;
    end
    starv   = nstarv;
    err_exp = derr;
    if (grant) occ[lid] = 1'b1;
    if (dok) occ[did] = 1'b0;
    #1;
    check_regs();
    $display("[TB] cyc v=%0d q=%0d dv=%0d did=%0d rdy=%0d id=%0d free=%0d starv=%0d err=%0d",
             v, q, dv, did, alloc_rdy, alloc_id, free_cnt, starv_mode, dealloc_err);
  endtask

  task automatic do_reset();
    alloc_vld   = 1'b1;
    alloc_qos   = 4'd15;
    dealloc_vld = 1'b0;
    resetn      = 1'b0;
    #1;
    chk("rst_validvec", entry_validvec, 0);
    chk("rst_free_cnt", free_cnt, N);
    chk("rst_starv", starv_mode, 0);
    chk("rst_err", dealloc_err, 0);
    chk("rst_alloc_rdy", alloc_rdy, 0);
    @(posedge clk);
    #2;
    alloc_vld = 1'b0;
    resetn    = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // fill all entries with high-QoS requests, then one more
    for (int i = 0; i < N; i++) cycle(1, 15, 0, 0);
    chk("full_free_cnt", free_cnt, 0);
    cycle(1, 12, 0, 0);

    // dealloc while full: no same-cycle reuse, entry 5 granted next cycle
    cycle(1, 15, 1, 5);
    cycle(1, 15, 0, 0);
    chk("reuse_free_cnt", free_cnt, 0);

    // dealloc of an already-free entry
    cycle(0, 0, 1, 7);
    cycle(0, 0, 1, 7);
    chk("err_pulse", dealloc_err, 1);
    cycle(0, 0, 0, 0);

    // reserve pool: normal blocked, high granted lowest free (7)
    for (int i = 8; i <= 10; i++) cycle(0, 0, 1, i);
    cycle(1, 3, 0, 0);
    cycle(1, 12, 0, 0);

    // starvation escalation with 4 free
    cycle(0, 0, 1, 7);
    for (int i = 0; i < THRESH; i++) cycle(1, 3, 0, 0);
    chk("starv_entered", starv_mode, 1);
    cycle(1, 3, 0, 0);
    chk("starv_exit", starv_mode, 0);

    // re-enter starvation then reset mid-operation
    for (int i = 0; i < THRESH; i++) cycle(1, 3, 0, 0);
    chk("starv_before_rst", starv_mode, 1);
    do_reset();
    cycle(1, 15, 0, 0);
    chk("first_after_rst", entry_validvec, 1);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 15),
            $urandom_range(0, 9) < 4, $urandom_range(0, N - 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
